vga_scanout: RTL and testbench



---
 rtl/vga_scanout.sv | 189 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scanout: 640x480@60 timing from a divided system clock, reading a 320x240x3 frame
// buffer through a synchronous port and showing each stored pixel as a 2x2 block.
module vga_scanout #(
  parameter int CLK_DIV = 2,
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [2:0]  fb_data,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic        VGA_SYNC,
  output logic        VGA_CLK,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_ACT = 2 * FB_W;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_ACT = 2 * FB_H;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0] V_PRE    = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [16:0]   FB_W17   = 17'(FB_W);

  // timing state
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  // fetch / capture pipeline: [0] is the read strobe, [1] marks fb_data valid
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic [16:0]   fb_addr_q, fb_addr_d;
  logic [2:0]    pix_hold_q, pix_hold_d;
  logic          act_s1_q, act_s1_d;
  logic          hs_raw_s1_q, hs_raw_s1_d;
  logic          vs_raw_s1_q, vs_raw_s1_d;

  // output registers
  logic [9:0]    vga_r_q, vga_r_d;
  logic [9:0]    vga_g_q, vga_g_d;
  logic [9:0]    vga_b_q, vga_b_d;
  logic          vga_hs_q, vga_hs_d;
  logic          vga_vs_q, vga_vs_d;
  logic          vga_blank_q, vga_blank_d;
  logic          vga_clk_q, vga_clk_d;
  logic          vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;

  logic          pix_tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic [16:0]   fetch_addr;

  always_comb begin
    pix_tick   = (div_cnt_q == DIV_LAST);
    h_wrap     = (h_cnt_q == H_LAST);
    v_wrap     = (v_cnt_q == V_LAST);
    active     = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_raw     = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
    vs_raw     = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
    // halving both counters repeats every address on two ticks and two lines
    fetch_addr = 17'(v_cnt_q >> 1) * FB_W17 + 17'(h_cnt_q >> 1);

    div_cnt_d     = pix_tick ? '0 : div_cnt_q + DW'(1);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    fb_addr_d     = fb_addr_q;
    act_s1_d      = act_s1_q;
    hs_raw_s1_d   = hs_raw_s1_q;
    vs_raw_s1_d   = vs_raw_s1_q;
    vga_r_d       = vga_r_q;
    vga_g_d       = vga_g_q;
    vga_b_d       = vga_b_q;
    vga_hs_d      = vga_hs_q;
    vga_vs_d      = vga_vs_q;
    vga_blank_d   = vga_blank_q;

    vga_clk_d     = (div_cnt_d < DIV_HALF);
    vld_pipe_d    = {vld_pipe_q[0], pix_tick && active};
    pix_hold_d    = vld_pipe_q[1] ? fb_data : pix_hold_q;
    frame_start_d = pix_tick && h_wrap && (v_cnt_q == V_PRE);

    if (pix_tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      if (active) fb_addr_d = fetch_addr;

      act_s1_d    = active;
      hs_raw_s1_d = hs_raw;
      vs_raw_s1_d = vs_raw;

      // with CLK_DIV=2 the read data arrives on this very tick, so take it straight from fb_data
      vga_r_d     = act_s1_q ? {10{pix_hold_d[2]}} : 10'h000;
      vga_g_d     = act_s1_q ? {10{pix_hold_d[1]}} : 10'h000;
      vga_b_d     = act_s1_q ? {10{pix_hold_d[0]}} : 10'h000;
      vga_blank_d = act_s1_q;
      vga_hs_d    = ~hs_raw_s1_q;
      vga_vs_d    = ~vs_raw_s1_q;
    end

    vblank_d = (v_cnt_d >= V_ACT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vld_pipe_q    <= '0;
      fb_addr_q     <= '0;
      pix_hold_q    <= '0;
      act_s1_q      <= 1'b0;
      hs_raw_s1_q   <= 1'b0;
      vs_raw_s1_q   <= 1'b0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_q   <= 1'b0;
      vga_clk_q     <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vld_pipe_q    <= vld_pipe_d;
      fb_addr_q     <= fb_addr_d;
      pix_hold_q    <= pix_hold_d;
      act_s1_q      <= act_s1_d;
      hs_raw_s1_q   <= hs_raw_s1_d;
      vs_raw_s1_q   <= vs_raw_s1_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_q   <= vga_blank_d;
      vga_clk_q     <= vga_clk_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd_en    = vld_pipe_q[0];
  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;
  assign VGA_HS      = vga_hs_q;
  assign VGA_VS      = vga_vs_q;
  assign VGA_BLANK   = vga_blank_q;
  assign VGA_SYNC    = 1'b0;
  assign VGA_CLK     = vga_clk_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a short frame (4 buffer rows, short back porch) keeps a full frame,
// its wrap and a mid-frame reset in a small cycle budget; expectations come from tick arithmetic.
module tb_vga_scanout;
  localparam int CLK_DIV = 2;
  localparam int FB_W = 320, FB_H = 4;
  localparam int H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_FP = 10, V_SYNC = 2, V_BP = 3;
  localparam int H_ACT = 2 * FB_W, H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_ACT = 2 * FB_H, V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME_TICKS = H_TOT * V_TOT;
  localparam int FRAME_CLKS  = FRAME_TICKS * CLK_DIV;
  localparam int RST_K = CLK_DIV * (FRAME_TICKS + 5 * H_TOT + 300);

  logic        clk, rst;
  logic [16:0] fb_addr;
  logic        fb_rd_en;
  logic [2:0]  fb_data;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK, vblank, frame_start;

  vga_scanout #(.CLK_DIV(CLK_DIV), .FB_W(FB_W), .FB_H(FB_H), .H_FP(H_FP), .H_SYNC(H_SYNC),
                .H_BP(H_BP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)) dut (
    .clk(clk), .rst(rst), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK), .vblank(vblank),
    .frame_start(frame_start));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] mem [0:(1<<17)-1];

  // synchronous RAM; junk on the bus whenever no read was issued
  always @(posedge clk) fb_data <= fb_rd_en ? mem[fb_addr] : 3'($urandom);

  typedef struct {
    int         k;
    logic       rd;
    int         addr;
    logic       blank;
    logic [2:0] rgb;
    logic       hs;
    logic       vclk;
  } vec_t;
  vec_t vecs[$];

  int checks = 0, errors = 0, k_now = 0, m_addr = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, act, exp);
    end
  endtask

  function automatic bit pos_act(input int q);
    return ((q % H_TOT) < H_ACT) && ((q / H_TOT) < V_ACT);
  endfunction

  function automatic int pos_addr(input int q);
    return ((q / H_TOT) / 2) * FB_W + (q % H_TOT) / 2;
  endfunction

  // k = clocks since the reset edge; t = pixel ticks completed by cycle k
  task automatic check_cycle(input int k);
    int t, q;
    logic e_rd, e_blank, e_hs, e_vs, e_vb, e_fs, e_ck;
    logic [2:0] e_pix;
    t = k / CLK_DIV;
    e_rd = 1'b0;
    if (k > 0 && k % CLK_DIV == 0 && pos_act((t - 1) % FRAME_TICKS)) begin
      e_rd = 1'b1;
      m_addr = pos_addr((t - 1) % FRAME_TICKS);
    end
    e_blank = 1'b0; e_pix = 3'd0; e_hs = 1'b1; e_vs = 1'b1;
    if (t >= 2) begin
      q = (t - 2) % FRAME_TICKS;
      e_blank = pos_act(q);
      if (e_blank) e_pix = mem[pos_addr(q)];
      e_hs = !((q % H_TOT) >= H_ACT + H_FP && (q % H_TOT) < H_ACT + H_FP + H_SYNC);
      e_vs = !((q / H_TOT) >= V_ACT + V_FP && (q / H_TOT) < V_ACT + V_FP + V_SYNC);
    end
    e_vb = ((t % FRAME_TICKS) / H_TOT) >= V_ACT;
    e_fs = (k > 0) && (k % CLK_DIV == 0) && ((t % FRAME_TICKS) == V_ACT * H_TOT);
    e_ck = (k > 0) && ((k % CLK_DIV) < CLK_DIV / 2);
    chk("fetch", k, 64'({fb_rd_en, fb_addr}), 64'({e_rd, 17'(m_addr)}));
    chk("colour", k, 64'({VGA_R, VGA_G, VGA_B, VGA_BLANK}),
        64'({{10{e_pix[2]}}, {10{e_pix[1]}}, {10{e_pix[0]}}, e_blank}));
    chk("sync", k, 64'({VGA_HS, VGA_VS, VGA_SYNC}), 64'({e_hs, e_vs, 1'b0}));
    chk("flags", k, 64'({vblank, frame_start, VGA_CLK}), 64'({e_vb, e_fs, e_ck}));
  endtask

  task automatic tab_check(input int k);
    foreach (vecs[i]) begin
      if (vecs[i].k == k) begin
        chk("vec_fetch", k, 64'({fb_rd_en, fb_addr}), 64'({vecs[i].rd, 17'(vecs[i].addr)}));
        chk("vec_pixel", k, 64'({VGA_R, VGA_G, VGA_B, VGA_BLANK}),
            64'({{10{vecs[i].rgb[2]}}, {10{vecs[i].rgb[1]}}, {10{vecs[i].rgb[0]}}, vecs[i].blank}));
        chk("vec_hs_clk", k, 64'({VGA_HS, VGA_CLK}), 64'({vecs[i].hs, vecs[i].vclk}));
      end
    end
  endtask

  task automatic add_vec(input int k, input logic rd, input int addr, input logic blank,
                         input logic [2:0] rgb, input logic hs, input logic vclk);
    vec_t v;
    v.k = k; v.rd = rd; v.addr = addr; v.blank = blank; v.rgb = rgb; v.hs = hs; v.vclk = vclk;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(negedge clk);
    k_now++;
    check_cycle(k_now);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k_now = 0;
    m_addr = 0;
    check_cycle(0);
  endtask

  int rd_cnt, fs_cnt, vs_low, vb_cnt, max_addr, hs_low;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < (1 << 17); i++) mem[i] = 3'(i);
    // cycle, rd_en, addr, blank, {R,G,B}, HS, VGA_CLK  (RAM data = addr[2:0])
    add_vec(0,    0, 0,   0, 3'd0, 1, 0);
    add_vec(1,    0, 0,   0, 3'd0, 1, 0);
    add_vec(2,    1, 0,   0, 3'd0, 1, 1);
    add_vec(3,    0, 0,   0, 3'd0, 1, 0);
    add_vec(4,    1, 0,   1, 3'd0, 1, 1);
    add_vec(6,    1, 1,   1, 3'd0, 1, 1);
    add_vec(8,    1, 1,   1, 3'd1, 1, 1);
    add_vec(22,   1, 5,   1, 3'd4, 1, 1);
    add_vec(24,   1, 5,   1, 3'd5, 1, 1);
    add_vec(25,   0, 5,   1, 3'd5, 1, 0);
    add_vec(1281, 0, 319, 1, 3'd7, 1, 0);
    add_vec(1282, 0, 319, 1, 3'd7, 1, 1);
    add_vec(1284, 0, 319, 0, 3'd0, 1, 1);
    add_vec(1315, 0, 319, 0, 3'd0, 1, 0);
    add_vec(1316, 0, 319, 0, 3'd0, 0, 1);
    add_vec(1507, 0, 319, 0, 3'd0, 0, 0);
    add_vec(1508, 0, 319, 0, 3'd0, 1, 1);
    add_vec(1602, 1, 0,   0, 3'd0, 1, 1);
    add_vec(1604, 1, 0,   1, 3'd0, 1, 1);
    repeat (3) @(negedge clk);

    // first line with a known pattern
    apply_reset();
    tab_check(0);
    rd_cnt = 0; hs_low = 0;
    for (int i = 1; i < 1700; i++) begin
      step();
      tab_check(k_now);
      if (k_now <= H_TOT * CLK_DIV) begin
        rd_cnt += int'(fb_rd_en);
        hs_low += int'(!VGA_HS);
      end
    end
    chk("line_fetches", k_now, 64'(rd_cnt), 64'(H_ACT));
    chk("line_hs_low_clks", k_now, 64'(hs_low), 64'(H_SYNC * CLK_DIV));

    // random image: a full frame, its wrap, then a reset in the middle of frame 2
    for (int i = 0; i < (1 << 17); i++) mem[i] = 3'($urandom);
    apply_reset();
    rd_cnt = 0; fs_cnt = 0; vs_low = 0; vb_cnt = 0; max_addr = 0;
    while (k_now < RST_K) begin
      step();
      if (k_now <= FRAME_CLKS) begin
        rd_cnt += int'(fb_rd_en);
        fs_cnt += int'(frame_start);
        vs_low += int'(!VGA_VS);
        vb_cnt += int'(vblank);
        if (fb_rd_en && int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
      end
    end
    chk("frame_fetches", k_now, 64'(rd_cnt), 64'(V_ACT * H_ACT));
    chk("frame_start_pulses", k_now, 64'(fs_cnt), 64'(1));
    chk("vs_low_clks", k_now, 64'(vs_low), 64'(V_SYNC * H_TOT * CLK_DIV));
    chk("vblank_clks", k_now, 64'(vb_cnt), 64'((V_TOT - V_ACT) * H_TOT * CLK_DIV));
    chk("last_addr", k_now, 64'(max_addr), 64'(FB_W * FB_H - 1));
    chk("pre_reset_blank", k_now, 64'(VGA_BLANK), 64'(1));

    apply_reset();
    chk("rst_fetch", 0, 64'({fb_rd_en, fb_addr}), 64'(0));
    chk("rst_colour", 0, 64'({VGA_R, VGA_G, VGA_B, VGA_BLANK}), 64'(0));
    chk("rst_sync", 0, 64'({VGA_HS, VGA_VS, VGA_SYNC}), 64'(3'b110));
    chk("rst_flags", 0, 64'({VGA_CLK, vblank, frame_start}), 64'(0));
    step();
    step();
    chk("restart_fetch", k_now, 64'({fb_rd_en, fb_addr}), 64'({1'b1, 17'd0}));
    repeat (3400) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
